// File: rtl/feature_accumulator.sv
// Feature accumulator: counts edge and curve events from asynchronous pins
// over one frame. At frame end it holds the saturated counts for the
// perceptron behind a valid/ready handshake.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for frame_start; outputs keep last loaded values
// ACCUM | frame open, counting feature events (busy=1)
// DONE  | result presented, feat_valid=1 until consumed by feat_ready

module feature_accumulator #(
  parameter int EDGE_W      = 3,
  parameter int CURVE_W     = 4,
  parameter int SYNC_STAGES = 2   // must be at least 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic               feat_stb,
  input  logic               feat_type,
  output logic [EDGE_W-1:0]  edges,
  output logic [CURVE_W-1:0] curves,
  output logic               feat_valid,
  input  logic               feat_ready,
  output logic               overflow,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NPIN = 4;  // {type, stb, end, start}
  localparam logic [EDGE_W-1:0]  EDGE_MAX  = '1;
  localparam logic [CURVE_W-1:0] CURVE_MAX = '1;

  // synchronizer chains and history flops for the event pins
  logic [SYNC_STAGES-1:0][NPIN-1:0] sync_q, sync_d;
  logic [2:0]                       hist_q, hist_d;
  logic [NPIN-1:0]                  synced;
  logic [2:0]                       evt;
  logic                             start_evt, end_evt, stb_evt, type_bit;

  // FSM, frame counters and output registers
  state_t               state_q, state_d;
  logic [EDGE_W-1:0]    edge_cnt_q, edge_cnt_d, edge_nxt;
  logic [CURVE_W-1:0]   curve_cnt_q, curve_cnt_d, curve_nxt;
  logic                 frame_ovf_q, frame_ovf_d, frame_ovf_nxt;
  logic [EDGE_W-1:0]    edges_q, edges_d;
  logic [CURVE_W-1:0]   curves_q, curves_d;
  logic                 overflow_q, overflow_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;

  // Shift pins through the synchronizer; history tracks the synced level.
  always_comb begin
    sync_d[0] = {feat_type, feat_stb, frame_end, frame_start};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    hist_d = sync_q[SYNC_STAGES-1][2:0];
  end

  // Synchronizer and history flops run independently of ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign synced    = sync_q[SYNC_STAGES-1];
  assign evt       = synced[2:0] & ~hist_q;
  assign start_evt = evt[0] & ena;
  assign end_evt   = evt[1] & ena;
  assign stb_evt   = evt[2] & ena;
  assign type_bit  = synced[3];

  // Saturating count update for a strobe in the current cycle.
  always_comb begin
    edge_nxt      = edge_cnt_q;
    curve_nxt     = curve_cnt_q;
    frame_ovf_nxt = frame_ovf_q;
    if (stb_evt) begin
      if (!type_bit) begin
        if (edge_cnt_q == EDGE_MAX) frame_ovf_nxt = 1'b1;
        else                        edge_nxt      = edge_cnt_q + EDGE_W'(1);
      end else begin
        if (curve_cnt_q == CURVE_MAX) frame_ovf_nxt = 1'b1;
        else                          curve_nxt     = curve_cnt_q + CURVE_W'(1);
      end
    end
  end

  // Next-state and output-register logic; ena=0 holds everything.
  always_comb begin
    state_d     = state_q;
    edge_cnt_d  = edge_cnt_q;
    curve_cnt_d = curve_cnt_q;
    frame_ovf_d = frame_ovf_q;
    edges_d     = edges_q;
    curves_d    = curves_q;
    overflow_d  = overflow_q;
    valid_d     = valid_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (start_evt) begin
            state_d     = ACCUM;
            edge_cnt_d  = '0;
            curve_cnt_d = '0;
            frame_ovf_d = 1'b0;
          end
        end
        ACCUM: begin
          // frame_end beats a simultaneous frame_start; a strobe in the
          // closing cycle is still included in the result.
          if (end_evt) begin
            edges_d     = edge_nxt;
            curves_d    = curve_nxt;
            overflow_d  = frame_ovf_nxt;
            valid_d     = 1'b1;
            state_d     = DONE;
          end else if (start_evt) begin
            edge_cnt_d  = '0;
            curve_cnt_d = '0;
            frame_ovf_d = 1'b0;
          end else begin
            edge_cnt_d  = edge_nxt;
            curve_cnt_d = curve_nxt;
            frame_ovf_d = frame_ovf_nxt;
          end
        end
        DONE: begin
          if (valid_q && feat_ready) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d == ACCUM);
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      edge_cnt_q  <= '0;
      curve_cnt_q <= '0;
      frame_ovf_q <= 1'b0;
      edges_q     <= '0;
      curves_q    <= '0;
      overflow_q  <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      edge_cnt_q  <= edge_cnt_d;
      curve_cnt_q <= curve_cnt_d;
      frame_ovf_q <= frame_ovf_d;
      edges_q     <= edges_d;
      curves_q    <= curves_d;
      overflow_q  <= overflow_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign edges      = edges_q;
  assign curves     = curves_q;
  assign overflow   = overflow_q;
  assign feat_valid = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_feature_accumulator.sv
// Testbench for feature_accumulator: randomized and directed pin pulses,
// a frame-level reference model feeding a scoreboard queue, and a monitor
// that checks every consumed result and the hold/drop protocol.

module tb_feature_accumulator;

  localparam int EDGE_W      = 3;
  localparam int CURVE_W     = 4;
  localparam int SYNC_STAGES = 2;
  localparam int EDGE_MAX    = (1 << EDGE_W) - 1;
  localparam int CURVE_MAX   = (1 << CURVE_W) - 1;

  logic clk = 1'b0;
  logic rst_n, ena, frame_start, frame_end, feat_stb, feat_type, feat_ready;
  logic [EDGE_W-1:0]  edges;
  logic [CURVE_W-1:0] curves;
  logic feat_valid, overflow, busy;

  always #5 clk = ~clk;

  feature_accumulator #(
    .EDGE_W(EDGE_W), .CURVE_W(CURVE_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .frame_start(frame_start), .frame_end(frame_end),
    .feat_stb(feat_stb), .feat_type(feat_type),
    .edges(edges), .curves(curves), .feat_valid(feat_valid),
    .feat_ready(feat_ready), .overflow(overflow), .busy(busy)
  );

  typedef struct {
    int e;
    int c;
    bit o;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  bit   have_last = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  // frame-level reference model
  bit m_in_frame = 0;
  bit m_pending  = 0;
  int m_e = 0, m_c = 0;
  bit m_o = 0;

  bit   rand_ready  = 0;
  logic ready_force = 1'b0;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void m_start();
    if (m_pending) return;          // result still waiting: frame pins dropped
    m_in_frame = 1;
    m_e = 0; m_c = 0; m_o = 0;
  endfunction

  function automatic void m_stb(bit t);
    if (!m_in_frame) return;
    if (t == 0) begin
      m_e = m_e + 1;
      if (m_e > EDGE_MAX) begin m_e = EDGE_MAX; m_o = 1; end
    end else begin
      m_c = m_c + 1;
      if (m_c > CURVE_MAX) begin m_c = CURVE_MAX; m_o = 1; end
    end
  endfunction

  function automatic void m_end();
    exp_t x;
    x.e = m_e; x.c = m_c; x.o = m_o;
    exp_q.push_back(x);
    m_in_frame = 0;
    m_pending  = 1;
  endfunction

  // ready driver
  initial begin
    feat_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      feat_ready = rand_ready ? logic'($urandom_range(0, 1)) : ready_force;
    end
  end

  // monitor / scoreboard
  initial begin : monitor
    bit prev_v, prev_hs, hs;
    int pe, pc, po;
    exp_t x;
    prev_v = 0; prev_hs = 0; pe = 0; pc = 0; po = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 0; prev_hs = 0;
      end else begin
        if (prev_hs) chk("valid_drop", feat_valid, 0);
        else if (prev_v) begin
          chk("valid_hold", feat_valid, 1);
          chk("hold_edges", edges, pe);
          chk("hold_curves", curves, pc);
          chk("hold_overflow", overflow, po);
        end
        hs = feat_valid && feat_ready && ena;
        if (hs) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_result: got edges=%0d curves=%0d, expected no result", edges, curves);
          end else begin
            x = exp_q.pop_front();
            chk("edges", edges, x.e);
            chk("curves", curves, x.c);
            chk("overflow", overflow, x.o);
            last_exp  = x;
            have_last = 1;
            m_pending = 0;
          end
        end
        prev_v = feat_valid; prev_hs = hs;
        pe = edges; pc = curves; po = overflow;
      end
    end
  end

  task automatic pulse(input bit s, input bit e, input bit st, input bit typ, output int lat);
    bit v0;
    @(posedge clk); #1 feat_type = typ;
    @(posedge clk); #1;
    frame_start = s; frame_end = e; feat_stb = st;
    v0 = feat_valid; lat = 0;
    if (ena) begin
      if (st) m_stb(typ);
      if (e && m_in_frame) m_end();
      else if (s) m_start();
    end
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (lat == 0 && !v0 && feat_valid) lat = i;
      if (i == 3) begin frame_start = 0; frame_end = 0; feat_stb = 0; end
    end
  endtask

  task automatic p(input bit s, input bit e, input bit st, input bit typ);
    int dummy;
    pulse(s, e, st, typ, dummy);
  endtask

  task automatic chk_busy(string name);
    chk(name, busy, m_in_frame);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (m_pending && k < 300) begin @(negedge clk); k++; end
    if (m_pending) begin
      n_checks++; n_errors++;
      $display("FAIL handshake_timeout: got no handshake in %0d cycles, expected one", k);
      m_pending = 0;
    end else if (have_last) begin
      @(negedge clk);
      chk("idle_keep_edges", edges, last_exp.e);
      chk("idle_keep_curves", curves, last_exp.c);
      chk("idle_keep_overflow", overflow, last_exp.o);
    end
  endtask

  initial begin : stim
    int lat, n;
    rst_n = 0; ena = 1; frame_start = 0; frame_end = 0; feat_stb = 0; feat_type = 0;
    #22;
    chk("rst_edges", edges, 0);
    chk("rst_curves", curves, 0);
    chk("rst_valid", feat_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (3) @(posedge clk);

    // basic frame with latency check
    ready_force = 0;
    p(1, 0, 0, 0);
    chk_busy("busy_after_start");
    repeat (2) p(0, 0, 1, 0);
    repeat (5) p(0, 0, 1, 1);
    pulse(0, 1, 0, 0, lat);
    chk("valid_latency_ok", (lat >= 1 && lat - 1 <= SYNC_STAGES + 2) ? 1 : 0, 1);
    chk("valid_after_end", feat_valid, 1);
    chk_busy("busy_in_done");
    ready_force = 1;
    wait_idle();

    // saturation
    p(1, 0, 0, 0);
    repeat (9)  p(0, 0, 1, 0);
    repeat (16) p(0, 0, 1, 1);
    p(0, 1, 0, 0);
    wait_idle();

    // strobe together with frame_end, then start together with end in ACCUM
    p(1, 0, 0, 0);
    p(0, 1, 1, 0);
    wait_idle();
    p(1, 0, 0, 0);
    p(0, 0, 1, 1);
    p(1, 1, 0, 0);
    chk_busy("busy_after_start_end");
    wait_idle();

    // backpressure with extra pulses ignored in DONE
    ready_force = 0;
    p(1, 0, 0, 0);
    repeat (3) p(0, 0, 1, 0);
    p(0, 1, 0, 0);
    p(1, 0, 0, 0);
    p(0, 0, 1, 1);
    p(0, 1, 0, 0);
    p(1, 0, 1, 0);
    repeat (20) @(posedge clk);
    chk("bp_valid", feat_valid, 1);
    ready_force = 1;
    wait_idle();
    chk_busy("busy_after_bp");

    // ena=0 drops events and freezes the handshake
    p(1, 0, 0, 0);
    repeat (2) p(0, 0, 1, 0);
    @(posedge clk); #1 ena = 0;
    repeat (3) p(0, 0, 1, 0);
    p(0, 0, 1, 1);
    p(0, 1, 0, 0);
    chk("ena0_busy", busy, 1);
    chk("ena0_valid", feat_valid, 0);
    @(posedge clk); #1 ena = 1;
    ready_force = 0;
    p(0, 0, 1, 1);
    p(0, 1, 0, 0);
    @(posedge clk); #1 ena = 0;
    ready_force = 1;
    repeat (6) @(posedge clk);
    chk("ena0_no_accept", feat_valid, 1);
    @(posedge clk); #1 ena = 1;
    wait_idle();

    // reset mid-frame
    p(1, 0, 0, 0);
    repeat (3) p(0, 0, 1, 0);
    @(negedge clk);
    rst_n = 0;
    exp_q.delete();
    m_in_frame = 0; m_pending = 0; have_last = 0;
    #1;
    chk("midrst_edges", edges, 0);
    chk("midrst_curves", curves, 0);
    chk("midrst_valid", feat_valid, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (3) @(posedge clk);
    p(0, 1, 0, 0);
    repeat (4) @(posedge clk);
    chk("post_rst_no_valid", feat_valid, 0);
    chk_busy("post_rst_busy");

    // randomized frames
    rand_ready = 1;
    for (int f = 0; f < 25; f++) begin
      wait_idle();
      p(1, 0, 0, 0);
      n = $urandom_range(0, 20);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 19) == 0) p(1, 0, 0, 0);
        else p(0, 0, 1, 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 3) == 0) p(0, 1, 1, 1'($urandom_range(0, 1)));
      else p(0, 1, 0, 0);
      chk_busy("rand_busy");
    end
    wait_idle();
    rand_ready = 0;
    repeat (5) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
